csr_unit: RTL and testbench
===========================

CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 Parameter TAG_W, default 6, width of the ROB tag carried with each CSR micro-op.
REQ-002 cpu_clock_i  in  1  sole clock; all state updates on rising edge.
REQ-003 cpu_reset_n_i  in  1  reset; asynchronous, active-low.
REQ-004 op_valid_i / op_ready_o  in / out  1 / 1  issue handshake; transfer when both high.
REQ-005 op_funct3_i  in  3  001 CSRRW, 010 CSRRS, 011 CSRRC, 101 CSRRWI, 110 CSRRSI, 111 CSRRCI.
REQ-006 op_csr_i  in  12  CSR address.
REQ-007 op_rs1_data_i  in  32  rs1 value.
REQ-008 op_rs1_idx_i  in  5  rs1 index; doubles as zimm for immediate forms.
REQ-009 op_rd_idx_i  in  5  destination register.
REQ-010 op_tag_i  in  TAG_W  ROB tag.
REQ-011 flush_i  in  1  pipeline flush, kills the held op.
REQ-012 csr_valid_o, csr_wr_en_o  out  1, 1  request strobe and write intent to the CSR file.
REQ-013 csr_address_o  out  12  CSR address; csr_opcode_o  out  2  01 write, 10 set, 11 clear; csr_data_o  out  32  operand.
REQ-014 csr_done_i, csr_excp_i  in  1, 1  completion and exception, valid one cycle after csr_valid_o; csr_rdata_i  in  32  old CSR value, valid with csr_done_i.
REQ-015 wb_valid_o / wb_ready_i  out / in  1 / 1  writeback handshake to commit.
REQ-016 wb_tag_o (TAG_W), wb_rd_o (5), wb_data_o (32), wb_we_o (1), wb_excp_o (1)  out  writeback payload.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, WB; exactly one op in flight.
REQ-018 op_ready_o = (state==IDLE) & !flush_i; on transfer, latch all op fields and go to ISSUE.
REQ-019 Operand = zero-extended op_rs1_idx_i when funct3[2]=1, else op_rs1_data_i; opcode = funct3[1:0].
REQ-020 csr_wr_en_o = 1 for RW/RWI; for set/clear forms, 1 only when the latched rs1 index/zimm is nonzero.
REQ-021 csr_valid_o = (state==ISSUE) & !flush_i, high for exactly one cycle per op; ISSUE -> WAIT unconditionally unless flush_i.
REQ-022 flush_i in ISSUE: csr_valid_o suppressed, go to IDLE, no CSR side effect, no writeback.
REQ-023 WAIT: on csr_done_i, capture csr_rdata_i and csr_excp_i, go to WB; if flush_i was seen in WAIT (sticky kill flag) or arrives with csr_done_i, go to IDLE with no writeback.
REQ-024 WB: wb_valid_o=1, payload stable until wb_ready_i; on wb_ready_i go to IDLE; flush_i in WB drops the result and goes to IDLE.
REQ-025 wb_we_o = (rd!=0) & !excp; wb_excp_o = captured csr_excp_i; wb_data_o = captured read data, 0 when excp.
REQ-026 Latency: op accepted cycle N -> csr_valid_o in N+1 -> csr_done_i in N+2 -> wb_valid_o from N+3; minimum 4 cycles between accepted ops.
REQ-027 csr_address_o, csr_opcode_o, csr_data_o, csr_wr_en_o driven from latched fields, stable throughout ISSUE and WAIT.
REQ-028 csr_done_i outside WAIT is ignored.

Reset
REQ-029 Reset low: state=IDLE, kill flag=0, op_ready_o=1 (flush_i low), csr_valid_o=0, wb_valid_o=0, all latched fields and wb payload 0.
REQ-030 Reset asserted mid-operation abandons the op immediately; no csr_valid_o or wb_valid_o after reset release until a new op is accepted.

Verification
REQ-031 CSRRW csr=0x340 rs1_data=0xDEADBEEF rd=5, csr_rdata_i=0x12 -> csr_valid_o N+1 with opcode 01, wr_en 1, data 0xDEADBEEF; wb_valid_o N+3, wb_data_o=0x12, wb_we_o=1.
REQ-032 CSRRS rs1_idx=0, rd=0 -> csr_wr_en_o=0; wb_we_o=0; CSRRSI zimm=3 -> wr_en 1, data 0x3, opcode 10.
REQ-033 csr_excp_i=1 with done -> wb_excp_o=1, wb_we_o=0, wb_data_o=0.
REQ-034 flush_i in ISSUE -> no csr_valid_o, IDLE next cycle; flush_i in WAIT -> done absorbed, no wb_valid_o.
REQ-035 wb_ready_i held low 5 cycles -> payload stable, op_ready_o=0 throughout; new op accepted the cycle after wb_ready_i.
REQ-036 cpu_reset_n_i low during WAIT -> all outputs at reset values same cycle; late csr_done_i ignored.

Source files
------------

// File: rtl/csr_unit.sv
// CSR execution unit: takes one CSR micro-op at a time, sends a single request to the CSR file,
// waits for the old value and hands it to commit through a writeback handshake.
module csr_unit #(
    parameter int unsigned TAG_W = 6
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_reset_n_i,

    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [2:0]       op_funct3_i,
    input  logic [11:0]      op_csr_i,
    input  logic [31:0]      op_rs1_data_i,
    input  logic [4:0]       op_rs1_idx_i,
    input  logic [4:0]       op_rd_idx_i,
    input  logic [TAG_W-1:0] op_tag_i,

    input  logic             flush_i,

    output logic             csr_valid_o,
    output logic             csr_wr_en_o,
    output logic [11:0]      csr_address_o,
    output logic [1:0]       csr_opcode_o,
    output logic [31:0]      csr_data_o,
    input  logic             csr_done_i,
    input  logic             csr_excp_i,
    input  logic [31:0]      csr_rdata_i,

    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      wb_data_o,
    output logic             wb_we_o,
    output logic             wb_excp_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StWb    = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   kill_q, kill_d;
    logic   accept;
    logic   capture;

    logic [2:0]       funct3_q;
    logic [11:0]      csr_q;
    logic [31:0]      rs1_data_q;
    logic [4:0]       rs1_idx_q;
    logic [4:0]       rd_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      rdata_q;
    logic             excp_q;

    assign op_ready_o = (state_q == StIdle) && !flush_i;
    assign accept     = op_valid_i && op_ready_o;

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                    kill_d  = 1'b0;
                end
            end
            StIssue: begin
                state_d = flush_i ? StIdle : StWait;
            end
            StWait: begin
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (csr_done_i) begin
                    // A flush seen at any point in WAIT swallows the response.
                    if (kill_q || flush_i) begin
                        state_d = StIdle;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = StWb;
                        capture = 1'b1;
                    end
                end
            end
            StWb: begin
                if (flush_i || wb_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            state_q <= StIdle;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            funct3_q   <= '0;
            csr_q      <= '0;
            rs1_data_q <= '0;
            rs1_idx_q  <= '0;
            rd_q       <= '0;
            tag_q      <= '0;
        end else if (accept) begin
            funct3_q   <= op_funct3_i;
            csr_q      <= op_csr_i;
            rs1_data_q <= op_rs1_data_i;
            rs1_idx_q  <= op_rs1_idx_i;
            rd_q       <= op_rd_idx_i;
            tag_q      <= op_tag_i;
        end
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            rdata_q <= '0;
            excp_q  <= 1'b0;
        end else if (capture) begin
            rdata_q <= csr_rdata_i;
            excp_q  <= csr_excp_i;
        end
    end

    // Set/clear with x0 or zimm 0 are pure reads and must not touch the CSR.
    assign csr_valid_o   = (state_q == StIssue) && !flush_i;
    assign csr_address_o = csr_q;
    assign csr_opcode_o  = funct3_q[1:0];
    assign csr_data_o    = funct3_q[2] ? {27'd0, rs1_idx_q} : rs1_data_q;
    assign csr_wr_en_o   = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);

    assign wb_valid_o = (state_q == StWb);
    assign wb_tag_o   = tag_q;
    assign wb_rd_o    = rd_q;
    assign wb_data_o  = excp_q ? 32'd0 : rdata_q;
    assign wb_we_o    = (rd_q != 5'd0) && !excp_q;
    assign wb_excp_o  = excp_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: inputs change on the falling edge, outputs are checked 1ns later.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op_funct3 = '0;
    logic [11:0] op_csr = '0;
    logic [31:0] op_rs1_data = '0;
    logic [4:0]  op_rs1_idx = '0;
    logic [4:0]  op_rd_idx = '0;
    logic [5:0]  op_tag = '0;
    logic        flush = 1'b0;
    logic        csr_valid;
    logic        csr_wr_en;
    logic [11:0] csr_address;
    logic [1:0]  csr_opcode;
    logic [31:0] csr_data;
    logic        csr_done = 1'b0;
    logic        csr_excp = 1'b0;
    logic [31:0] csr_rdata = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [5:0]  wb_tag;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        wb_excp;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csr_unit #(.TAG_W(6)) dut (
        .cpu_clock_i   (clk),
        .cpu_reset_n_i (rst_n),
        .op_valid_i    (op_valid),
        .op_ready_o    (op_ready),
        .op_funct3_i   (op_funct3),
        .op_csr_i      (op_csr),
        .op_rs1_data_i (op_rs1_data),
        .op_rs1_idx_i  (op_rs1_idx),
        .op_rd_idx_i   (op_rd_idx),
        .op_tag_i      (op_tag),
        .flush_i       (flush),
        .csr_valid_o   (csr_valid),
        .csr_wr_en_o   (csr_wr_en),
        .csr_address_o (csr_address),
        .csr_opcode_o  (csr_opcode),
        .csr_data_o    (csr_data),
        .csr_done_i    (csr_done),
        .csr_excp_i    (csr_excp),
        .csr_rdata_i   (csr_rdata),
        .wb_valid_o    (wb_valid),
        .wb_ready_i    (wb_ready),
        .wb_tag_o      (wb_tag),
        .wb_rd_o       (wb_rd),
        .wb_data_o     (wb_data),
        .wb_we_o       (wb_we),
        .wb_excp_o     (wb_excp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents an op in IDLE; returns 1ns into the ISSUE cycle.
    task automatic accept(input logic [2:0] f3, input logic [11:0] csr, input logic [31:0] d,
                          input logic [4:0] idx, input logic [4:0] rd, input logic [5:0] tag);
        op_valid    = 1'b1;
        op_funct3   = f3;
        op_csr      = csr;
        op_rs1_data = d;
        op_rs1_idx  = idx;
        op_rd_idx   = rd;
        op_tag      = tag;
        #1;
        chk("accept_ready", 32'(op_ready), 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        #1;
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_csr_valid", 32'(csr_valid), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_csr_addr", 32'(csr_address), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // CSRRW mscratch
        accept(3'b001, 12'h340, 32'hDEADBEEF, 5'd7, 5'd5, 6'h2A);
        chk("rw_csr_valid", 32'(csr_valid), 32'd1);
        chk("rw_opcode", 32'(csr_opcode), 32'd1);
        chk("rw_wr_en", 32'(csr_wr_en), 32'd1);
        chk("rw_data", csr_data, 32'hDEADBEEF);
        chk("rw_addr", 32'(csr_address), 32'h340);
        chk("rw_busy", 32'(op_ready), 32'd0);
        @(negedge clk);
        csr_done = 1'b1; csr_rdata = 32'h12;
        #1;
        chk("rw_valid_once", 32'(csr_valid), 32'd0);
        chk("rw_addr_wait", 32'(csr_address), 32'h340);
        chk("rw_no_wb_yet", 32'(wb_valid), 32'd0);
        @(negedge clk);
        csr_done = 1'b0; csr_rdata = 32'hFFFF_FFFF; wb_ready = 1'b1;
        #1;
        chk("rw_wb_valid", 32'(wb_valid), 32'd1);
        chk("rw_wb_data", wb_data, 32'h12);
        chk("rw_wb_we", 32'(wb_we), 32'd1);
        chk("rw_wb_rd", 32'(wb_rd), 32'd5);
        chk("rw_wb_tag", 32'(wb_tag), 32'h2A);
        chk("rw_wb_excp", 32'(wb_excp), 32'd0);
        @(negedge clk);
        wb_ready = 1'b0;
        #1;
        chk("rw_back_idle", 32'(op_ready), 32'd1);
        chk("rw_wb_drop", 32'(wb_valid), 32'd0);

        // CSRRS x0 into x0: read only
        accept(3'b010, 12'h300, 32'h0000_0055, 5'd0, 5'd0, 6'h01);
        chk("rs_wr_en", 32'(csr_wr_en), 32'd0);
        chk("rs_opcode", 32'(csr_opcode), 32'd2);
        chk("rs_data", csr_data, 32'h55);
        @(negedge clk);
        csr_done = 1'b1; csr_rdata = 32'h77;
        @(negedge clk);
        csr_done = 1'b0; wb_ready = 1'b1;
        #1;
        chk("rs_wb_data", wb_data, 32'h77);
        chk("rs_wb_we", 32'(wb_we), 32'd0);
        @(negedge clk);
        wb_ready = 1'b0;

        // CSRRSI zimm=3
        accept(3'b110, 12'h304, 32'hFFFF_FFFF, 5'd3, 5'd4, 6'h02);
        chk("rsi_wr_en", 32'(csr_wr_en), 32'd1);
        chk("rsi_data", csr_data, 32'h3);
        chk("rsi_opcode", 32'(csr_opcode), 32'd2);
        @(negedge clk);
        csr_done = 1'b1; csr_rdata = 32'h8;
        @(negedge clk);
        csr_done = 1'b0; wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;

        // CSRRCI zimm=0 is read only
        accept(3'b111, 12'h305, 32'h1234_5678, 5'd0, 5'd6, 6'h03);
        chk("rci_wr_en", 32'(csr_wr_en), 32'd0);
        chk("rci_opcode", 32'(csr_opcode), 32'd3);
        chk("rci_data", csr_data, 32'h0);
        @(negedge clk);
        csr_done = 1'b1; csr_rdata = 32'h9;
        @(negedge clk);
        csr_done = 1'b0; wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;

        // Exception response
        accept(3'b001, 12'hC00, 32'h1, 5'd1, 5'd3, 6'h04);
        @(negedge clk);
        csr_done = 1'b1; csr_excp = 1'b1; csr_rdata = 32'hABCD;
        @(negedge clk);
        csr_done = 1'b0; csr_excp = 1'b0; wb_ready = 1'b1;
        #1;
        chk("ex_wb_valid", 32'(wb_valid), 32'd1);
        chk("ex_wb_excp", 32'(wb_excp), 32'd1);
        chk("ex_wb_we", 32'(wb_we), 32'd0);
        chk("ex_wb_data", wb_data, 32'd0);
        @(negedge clk);
        wb_ready = 1'b0;

        // Flush in ISSUE
        op_valid = 1'b1; op_funct3 = 3'b001; op_csr = 12'h341; op_rs1_data = 32'h5;
        op_rs1_idx = 5'd2; op_rd_idx = 5'd8; op_tag = 6'h05;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b1;
        #1;
        chk("fi_csr_valid", 32'(csr_valid), 32'd0);
        chk("fi_ready_masked", 32'(op_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fi_idle", 32'(op_ready), 32'd1);
        chk("fi_no_valid", 32'(csr_valid), 32'd0);

        // Flush in WAIT, done arrives a cycle later
        accept(3'b010, 12'h342, 32'h0, 5'd4, 5'd9, 6'h06);
        chk("fw_csr_valid", 32'(csr_valid), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; csr_done = 1'b1; csr_rdata = 32'h9;
        #1;
        chk("fw_still_wait", 32'(op_ready), 32'd0);
        @(negedge clk);
        csr_done = 1'b0;
        #1;
        chk("fw_no_wb", 32'(wb_valid), 32'd0);
        chk("fw_idle", 32'(op_ready), 32'd1);

        // Writeback backpressure for 5 cycles
        accept(3'b011, 12'h343, 32'hF0, 5'd10, 5'd9, 6'h07);
        @(negedge clk);
        csr_done = 1'b1; csr_rdata = 32'h1234;
        @(negedge clk);
        csr_done = 1'b0; csr_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_wb_valid", 32'(wb_valid), 32'd1);
            chk("bp_wb_data", wb_data, 32'h1234);
            chk("bp_wb_tag", 32'(wb_tag), 32'h07);
            chk("bp_busy", 32'(op_ready), 32'd0);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        op_valid = 1'b1; op_funct3 = 3'b101; op_csr = 12'h344; op_rs1_idx = 5'd17;
        op_rd_idx = 5'd1; op_tag = 6'h08;
        #1;
        chk("bp_no_accept_in_wb", 32'(op_ready), 32'd0);
        @(negedge clk);
        wb_ready = 1'b0;
        #1;
        chk("bp_accept_next", 32'(op_ready), 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        chk("bp_new_issue", 32'(csr_valid), 32'd1);
        chk("bp_new_data", csr_data, 32'd17);
        chk("bp_new_addr", 32'(csr_address), 32'h344);

        // Reset during WAIT, late done ignored
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_ready", 32'(op_ready), 32'd1);
        chk("rw_rst_csr_valid", 32'(csr_valid), 32'd0);
        chk("rw_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rw_rst_addr", 32'(csr_address), 32'd0);
        chk("rw_rst_tag", 32'(wb_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; csr_done = 1'b1; csr_rdata = 32'h55;
        #1;
        chk("late_done_csr_valid", 32'(csr_valid), 32'd0);
        chk("late_done_ready", 32'(op_ready), 32'd1);
        @(negedge clk);
        csr_done = 1'b0;
        #1;
        chk("late_done_wb", 32'(wb_valid), 32'd0);
        chk("late_done_idle", 32'(op_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
